// File: rtl/serial_detect_ctrl.sv
// Serial sequence-detector sequencer: latches a word, clears the detector, shifts the word MSB-first
// and reports how many cycles the detector raised Z. Optional abort port under `SDC_ABORT_EN`.
module serial_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              det_x,
  output logic              det_en,
  output logic              det_clr,
  input  logic              det_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
`ifdef SDC_ABORT_EN
  ,input logic              abort
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              last_bit;
  logic              abort_req;

  assign last_bit = (idx == IDX_W'(WORD_W - 1));

`ifdef SDC_ABORT_EN
  assign abort_req = abort && (state == CLEAR || state == SHIFT);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    det_x     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        det_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_en = 1'b1;
        det_x  = sreg[WORD_W-1];
        if (last_bit) state_nxt = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  // Counter is left holding the last report in IDLE; it is zeroed on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg <= in_word;
          idx  <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          sreg <= {sreg[WORD_W-2:0], 1'b0};
          idx  <= idx + IDX_W'(1);
          if (det_z && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
      if (abort_req) begin
        idx <= '0;
        cnt <= '0;
      end
    end
  end

  assign out_count = cnt;

endmodule

// File: tb/tb_serial_detect_ctrl.sv
// Bench for serial_detect_ctrl: stub detector (Z = X, or forced 1), expected counts queued on
// accept and compared on each report handshake; a CNT_W=3 copy checks saturation.
module tb_serial_detect_ctrl;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0, reset_n = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b1, force_z = 1'b0;
  logic [WORD_W-1:0] in_word = '0;
  logic              in_ready, det_x, det_en, det_clr, det_z, out_valid, busy;
  logic [CNT_W-1:0]  out_count;
  logic              s_in_ready, s_det_x, s_det_en, s_det_clr, s_det_z, s_out_valid, s_busy;
  logic [2:0]        s_out_count;
`ifdef SDC_ABORT_EN
  logic              abort = 1'b0;
`endif

  assign det_z   = force_z | det_x;
  assign s_det_z = force_z | s_det_x;

  serial_detect_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .det_x(det_x), .det_en(det_en), .det_clr(det_clr), .det_z(det_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
`ifdef SDC_ABORT_EN
    , .abort(abort)
`endif
  );

  serial_detect_ctrl #(.WORD_W(WORD_W), .CNT_W(3)) u_sat (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_word(in_word), .det_x(s_det_x), .det_en(s_det_en), .det_clr(s_det_clr), .det_z(s_det_z),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_count(s_out_count), .busy(s_busy)
`ifdef SDC_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clock = ~clock;

  int nvec = 0, nerr = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: detector-port history and report scoreboard, sampled mid-cycle.
  int                cyc = 0, en_cnt = 0, clr_cnt = 0, last_clr_cyc = 0, clr_gap = 0;
  logic [WORD_W-1:0] xbits = '0;
  logic              clr_pend = 1'b0, prev_en = 1'b0, seen_ov = 1'b0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    int e;
    if (det_en) begin
      xbits = {xbits[WORD_W-2:0], det_x};
      en_cnt++;
    end
    if (det_clr) begin
      clr_cnt++;
      clr_gap      = cyc - last_clr_cyc;
      last_clr_cyc = cyc;
      clr_pend     = 1'b1;
    end
    if (det_en && !prev_en) begin
      check("clr_before_en", {31'd0, clr_pend}, 1);
      clr_pend = 1'b0;
    end
    prev_en = det_en;
    if (out_valid) seen_ov = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_report", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_count", {28'd0, out_count}, e);
        check("out_count_sat3", {29'd0, s_out_count}, (e > 7) ? 7 : e);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    check(name, {31'd0, in_ready}, 1);
  endtask

  task automatic send(input logic [WORD_W-1:0] w, input int exp, input logic fz);
    wait_ready("ready_timeout");
    in_word  = w;
    force_z  = fz;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick; n++; end
    check(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [WORD_W-1:0] word;
    logic              fz;
    int                exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, n, c0;
    tbl[0] = '{8'h00, 1'b0, 0};
    tbl[1] = '{8'hFF, 1'b0, 8};
    tbl[2] = '{8'hFF, 1'b1, 8};
    tbl[3] = '{8'h00, 1'b1, 8};
    tbl[4] = '{8'h55, 1'b0, 4};
    tbl[5] = '{8'h80, 1'b0, 1};
    tbl[6] = '{8'h01, 1'b0, 1};
    tbl[7] = '{8'h7E, 1'b0, 6};
    tbl[8] = '{8'hC3, 1'b0, 4};

    // Reset state
    tick; tick;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_count", {28'd0, out_count}, 0);
    check("rst_det_outs", {29'd0, det_x, det_en, det_clr}, 0);
    reset_n = 1'b1;
    tick;

    // 1011_0010: bit order, count, latency
    xbits  = '0;
    en_cnt = 0;
    send(8'hB2, 4, 1'b0);
    lat = 1;
    while (!out_valid && lat < 50) begin tick; lat++; end
    check("latency", lat, WORD_W + 2);
    check("det_x_seq", {24'd0, xbits}, 32'hB2);
    check("shift_cycles", en_cnt, WORD_W);
    drain("drain_b2");

    // Table vectors
    foreach (tbl[i]) begin
      send(tbl[i].word, tbl[i].exp, tbl[i].fz);
      drain("drain_tbl");
    end
    force_z = 1'b0;

    // Report stall with a word offered meanwhile
    out_ready = 1'b0;
    send(8'h3C, 4, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    in_word  = 8'h81;
    in_valid = 1'b1;
    exp_q.push_back(2);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_count", {28'd0, out_count}, 4);
      check("stall_in_ready", {31'd0, in_ready}, 0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    check("post_report_idle", {30'd0, in_ready, busy}, 32'd2);
    tick;
    check("accept_after_report", {30'd0, det_clr, in_ready}, 32'd2);
    in_valid = 1'b0;
    drain("drain_stall");

    // Back-to-back words with in_valid held
    wait_ready("ready_b2b");
    c0       = clr_cnt;
    in_word  = 8'h0F;
    in_valid = 1'b1;
    exp_q.push_back(4);
    tick;
    in_word = 8'hA5;
    exp_q.push_back(4);
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    tick;
    in_valid = 1'b0;
    drain("drain_b2b");
    check("clr_pulses", clr_cnt - c0, 2);
    check("word_period", clr_gap, WORD_W + 3);

    // Reset mid-SHIFT discards the word
    send(8'hFF, 8, 1'b0);
    tick; tick; tick;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_in_ready", {31'd0, in_ready}, 1);
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_det", {29'd0, det_x, det_en, det_clr}, 0);
    check("async_rst_out", {27'd0, out_valid, out_count}, 0);
    void'(exp_q.pop_back());
    tick;
    reset_n = 1'b1;
    seen_ov = 1'b0;
    repeat (20) tick;
    check("no_report_after_reset", {31'd0, seen_ov}, 0);
    send(8'h96, 4, 1'b0);
    drain("drain_post_reset");

`ifdef SDC_ABORT_EN
    // Abort in the 3rd SHIFT cycle
    send(8'hFF, 8, 1'b0);
    void'(exp_q.pop_back());
    tick; tick; tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_idle", {30'd0, in_ready, busy}, 32'd2);
    check("abort_det_en", {31'd0, det_en}, 0);
    check("abort_cnt_clr", {28'd0, out_count}, 0);
    seen_ov = 1'b0;
    repeat (12) tick;
    check("abort_no_report", {31'd0, seen_ov}, 0);
    send(8'h5A, 4, 1'b0);
    drain("drain_post_abort");
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
